// File: rtl/fanin_collector.sv
// N-to-1 gather stage: each source lane parks one word in a private holding register,
// and a round-robin arbiter drains those registers into a single registered valid/ready output.
module fanin_collector #(
    parameter int  N_SRC  = 16,
    parameter int  DATA_W = 8,
    localparam int IDX_W  = $clog2(N_SRC)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_SRC-1:0]          src_valid,
    input  logic [N_SRC*DATA_W-1:0]   src_data,
    output logic [N_SRC-1:0]          src_ready,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    output logic [IDX_W-1:0]          out_src,
    input  logic                      out_ready,
    output logic [IDX_W:0]            pending
);

    logic [N_SRC-1:0]  hold_full_q, hold_full_d;
    logic [DATA_W-1:0] hold_data_q [N_SRC];
    logic [DATA_W-1:0] hold_data_d [N_SRC];
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [IDX_W-1:0]  out_src_q, out_src_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IDX_W:0]    pending_q, pending_d;

    logic              slot_free_s;
    logic              win_found_s;
    logic [IDX_W-1:0]  win_idx_s;
    logic [N_SRC-1:0]  capture_s;

    function automatic logic [IDX_W:0] popcount(input logic [N_SRC-1:0] vec);
        logic [IDX_W:0] cnt;
        cnt = '0;
        for (int i = 0; i < N_SRC; i++) begin
            cnt = cnt + (IDX_W+1)'(vec[i]);
        end
        return cnt;
    endfunction

    // Round-robin winner: first full lane at or after rr_ptr, wrapping at N_SRC.
    always_comb begin
        int idx;
        win_found_s = 1'b0;
        win_idx_s   = '0;
        idx         = 0;
        for (int k = 0; k < N_SRC; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= N_SRC) begin
                idx = idx - N_SRC;
            end else begin
                idx = idx;
            end
            if (!win_found_s && hold_full_q[idx]) begin
                win_found_s = 1'b1;
                win_idx_s   = IDX_W'(idx);
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Next-state for holding registers, output slot, pointer and occupancy count.
    always_comb begin
        slot_free_s = ~out_valid_q | out_ready;
        capture_s   = src_valid & ~hold_full_q;
        hold_full_d = hold_full_q;
        for (int i = 0; i < N_SRC; i++) begin
            hold_data_d[i] = hold_data_q[i];
        end
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        rr_ptr_d    = rr_ptr_q;

        if (slot_free_s) begin
            if (win_found_s) begin
                out_valid_d            = 1'b1;
                out_data_d             = hold_data_q[win_idx_s];
                out_src_d              = win_idx_s;
                hold_full_d[win_idx_s] = 1'b0;
                if (win_idx_s == IDX_W'(N_SRC-1)) begin
                    rr_ptr_d = '0;
                end else begin
                    rr_ptr_d = win_idx_s + IDX_W'(1);
                end
            end else begin
                out_valid_d = 1'b0;
            end
        end else begin
            out_valid_d = out_valid_q;
        end

        // A lane being granted this edge was full, so it cannot also capture now.
        for (int i = 0; i < N_SRC; i++) begin
            if (capture_s[i]) begin
                hold_full_d[i] = 1'b1;
                hold_data_d[i] = src_data[i*DATA_W +: DATA_W];
            end else begin
                hold_data_d[i] = hold_data_d[i];
            end
        end

        pending_d = popcount(hold_full_d);
    end

    // State registers; reset discards every held and output word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_full_q <= '0;
            for (int i = 0; i < N_SRC; i++) begin
                hold_data_q[i] <= '0;
            end
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            rr_ptr_q    <= '0;
            pending_q   <= '0;
        end else begin
            hold_full_q <= hold_full_d;
            for (int i = 0; i < N_SRC; i++) begin
                hold_data_q[i] <= hold_data_d[i];
            end
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            rr_ptr_q    <= rr_ptr_d;
            pending_q   <= pending_d;
        end
    end

    assign src_ready = ~hold_full_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign pending   = pending_q;

endmodule
